// File: rtl/dds_pkg.sv
// Shared types for the waveform generator / frequency meter path.
package dds_pkg;

    localparam int unsigned WAVE_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEASURE,
        ST_DONE
    } meas_state_t;

    typedef enum logic {
        H_HIGH,
        H_LOW
    } hyst_state_t;

    // Waveform select codes used by the generator side.
    typedef enum logic [1:0] {
        WAVE_SINE,
        WAVE_SQUARE,
        WAVE_SAW,
        WAVE_TRI
    } wave_sel_t;

endpackage

// File: rtl/hyst_xing_det.sv
// Registers the incoming sample and flags rising mid-scale crossings with hysteresis.
// The detector free-runs so its armed/unarmed state is already known when a gate opens.
module hyst_xing_det
    import dds_pkg::*;
#(
    parameter logic [WAVE_W-1:0] MID  = 16'h8000,
    parameter logic [WAVE_W-1:0] HYST = 16'd1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_valid,
    input  logic [WAVE_W-1:0] sample,
    output logic              xing_c
);

    localparam logic [WAVE_W-1:0] LO_TH = MID - HYST;
    localparam logic [WAVE_W-1:0] HI_TH = MID + HYST;

    logic [WAVE_W-1:0] s_q;
    logic              v_q;
    hyst_state_t       state_q;
    hyst_state_t       state_d;

    // Input stage and hysteresis state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q     <= '0;
            v_q     <= 1'b0;
            state_q <= H_HIGH;
        end else begin
            s_q     <= sample;
            v_q     <= sample_valid;
            state_q <= state_d;
        end
    end

    // Invalid samples hold state; the LOW->HIGH step is the crossing.
    always_comb begin
        state_d = state_q;
        xing_c  = 1'b0;
        if (v_q) begin
            case (state_q)
                H_HIGH: if (s_q < LO_TH) state_d = H_LOW;
                H_LOW: begin
                    if (s_q >= HI_TH) begin
                        state_d = H_HIGH;
                        xing_c  = 1'b1;
                    end
                end
                default: state_d = H_HIGH;
            endcase
        end
    end

endmodule

// File: rtl/dds_freq_meter.sv
// Gated crossing counter: reports crossings and the clock span from first to last
// crossing so software can derive fout = (edge_count-1)*fclk/span_cycles.
module dds_freq_meter
    import dds_pkg::*;
#(
    parameter int unsigned       GATE_CYCLES = 1000000,
    parameter logic [WAVE_W-1:0] MID         = 16'h8000,
    parameter logic [WAVE_W-1:0] HYST        = 16'd1024,
    parameter int unsigned       CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sample_valid,
    input  logic [WAVE_W-1:0] sample,
    output logic              busy,
    output logic              done,
    output logic [15:0]       edge_count,
    output logic [CNT_W-1:0]  span_cycles,
    output logic              no_signal
);

    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);
    localparam logic [15:0]      EDGE_MAX  = 16'hFFFF;

    logic              xing_c;
    meas_state_t       state_q;
    meas_state_t       state_d;
    logic [CNT_W-1:0]  gate_q;
    logic [CNT_W-1:0]  gate_d;
    logic [CNT_W-1:0]  span_q;
    logic [CNT_W-1:0]  span_d;
    logic [CNT_W-1:0]  last_span_q;
    logic [CNT_W-1:0]  last_span_d;
    logic [15:0]       edges_q;
    logic [15:0]       edges_d;

    hyst_xing_det #(
        .MID  (MID),
        .HYST (HYST)
    ) u_det (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample       (sample),
        .xing_c       (xing_c)
    );

    // State and counter registers; results capture on entry to DONE so they align with done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            gate_q      <= '0;
            span_q      <= '0;
            last_span_q <= '0;
            edges_q     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            edge_count  <= '0;
            span_cycles <= '0;
            no_signal   <= 1'b0;
        end else begin
            state_q     <= state_d;
            gate_q      <= gate_d;
            span_q      <= span_d;
            last_span_q <= last_span_d;
            edges_q     <= edges_d;
            busy        <= (state_d == ST_ARM) || (state_d == ST_MEASURE);
            done        <= (state_d == ST_DONE);
            if (state_d == ST_DONE) begin
                edge_count  <= edges_d;
                span_cycles <= last_span_d;
                no_signal   <= (edges_d < 16'd2);
            end
        end
    end

    // Next state and counter updates; a crossing on the final gate cycle is still counted.
    always_comb begin
        state_d     = state_q;
        gate_d      = gate_q;
        span_d      = span_q;
        last_span_d = last_span_q;
        edges_d     = edges_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_ARM;
                    gate_d      = '0;
                    span_d      = '0;
                    last_span_d = '0;
                    edges_d     = '0;
                end
            end
            ST_ARM: begin
                gate_d = gate_q + CNT_W'(1);
                if (xing_c) begin
                    state_d     = ST_MEASURE;
                    edges_d     = 16'd1;
                    span_d      = '0;
                    last_span_d = '0;
                end
                if (gate_q == GATE_LAST) state_d = ST_DONE;
            end
            ST_MEASURE: begin
                gate_d = gate_q + CNT_W'(1);
                span_d = span_q + CNT_W'(1);
                if (xing_c) begin
                    edges_d     = (edges_q == EDGE_MAX) ? edges_q : edges_q + 16'd1;
                    last_span_d = span_q + CNT_W'(1);
                end
                if (gate_q == GATE_LAST) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
